dds_cfg_arbiter: RTL and testbench

//   Shares the single DDS configuration port (pinc/poff + cfg_valid strobe) between N requesters
//   (sweep controller, host register bank, test-pattern source, ...). Round-robin arbitration,
//   one config strobe per grant, programmable hold-off between strobes so DDS phase settles.

---
 rtl/dds_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/dds_cfg_arbiter.sv | 106 ++++++++++
 tb/tb_dds_cfg_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared types for the DDS configuration arbiter
package dds_pkg;

    localparam int DDS_PW = 16;

    typedef struct packed {
        logic [DDS_PW-1:0] pinc;
        logic [DDS_PW-1:0] poff;
    } dds_cfg_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_HOLDOFF
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching upward from last_grant+1
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic          found;
    logic [IW-1:0] k;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        k         = '0;
        // offset N wraps back to last_grant itself, so it is tried last
        for (int i = 1; i <= N; i++) begin
            k = IW'((int'(last_grant) + i) % N);
            if (!found && req[k]) begin
                found     = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = k;
            end
        end
    end

endmodule

// File: rtl/dds_cfg_arbiter.sv
// rtl/dds_cfg_arbiter.sv - shares the DDS pinc/poff config port between N requesters
module dds_cfg_arbiter
    import dds_pkg::*;
#(
    parameter int N_REQ          = 3,
    parameter int HOLDOFF_CYCLES = 4,
    parameter int PW             = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_enable,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [N_REQ*PW-1:0]      i_req_pinc,
    input  logic [N_REQ*PW-1:0]      i_req_poff,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic [PW-1:0]            o_pinc,
    output logic [PW-1:0]            o_poff,
    output logic                     o_cfg_valid,
    output logic [$clog2(N_REQ)-1:0] o_src,
    output logic                     o_busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (HOLDOFF_CYCLES > 0) ? CW'(HOLDOFF_CYCLES - 1) : '0;

    arb_state_t     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  pinc_q, pinc_d;
    logic [PW-1:0]  poff_q, poff_d;
    logic [IW-1:0]  src_q, src_d;
    logic [IW-1:0]  last_q, last_d;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]  win_idx;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req        (i_req_valid),
        .last_grant (last_q),
        .grant      (grant),
        .grant_idx  (win_idx)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pinc_d      = pinc_q;
        poff_d      = poff_q;
        src_d       = src_q;
        last_d      = last_q;
        o_req_ready = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (i_enable && (|i_req_valid)) begin
                    o_req_ready = grant;
                    pinc_d      = i_req_pinc[int'(win_idx)*PW +: PW];
                    poff_d      = i_req_poff[int'(win_idx)*PW +: PW];
                    src_d       = win_idx;
                    last_d      = win_idx;
                    state_d     = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (HOLDOFF_CYCLES == 0) begin
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = ARB_HOLDOFF;
                end
            end
            ARB_HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // last_q starts at N_REQ-1 so requester 0 wins the first arbitration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            pinc_q  <= '0;
            poff_q  <= '0;
            src_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pinc_q  <= pinc_d;
            poff_q  <= poff_d;
            src_q   <= src_d;
            last_q  <= last_d;
        end
    end

    assign o_pinc      = pinc_q;
    assign o_poff      = poff_q;
    assign o_src       = src_q;
    assign o_cfg_valid = (state_q == ARB_ISSUE);
    assign o_busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_dds_cfg_arbiter.sv
// tb/tb_dds_cfg_arbiter.sv - bench for dds_cfg_arbiter (hold-off 4 and hold-off 0 instances)
module tb_dds_cfg_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en0 = 1'b1, en1 = 1'b1;
    logic [2:0]  v0 = '0, v1 = '0;
    logic [47:0] pi0 = '0, po0 = '0, pi1 = '0, po1 = '0;
    logic [2:0]  rdy0, rdy1;
    logic [15:0] opi0, opo0, opi1, opo1;
    logic        cfg0, cfg1, busy0, busy1;
    logic [1:0]  src0, src1;

    always #5 clk = ~clk;

    dds_cfg_arbiter #(.N_REQ(3), .HOLDOFF_CYCLES(4), .PW(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_enable(en0), .i_req_valid(v0),
        .i_req_pinc(pi0), .i_req_poff(po0), .o_req_ready(rdy0),
        .o_pinc(opi0), .o_poff(opo0), .o_cfg_valid(cfg0), .o_src(src0), .o_busy(busy0)
    );

    dds_cfg_arbiter #(.N_REQ(3), .HOLDOFF_CYCLES(0), .PW(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_enable(en1), .i_req_valid(v1),
        .i_req_pinc(pi1), .i_req_poff(po1), .o_req_ready(rdy1),
        .o_pinc(opi1), .o_poff(opo1), .o_cfg_valid(cfg1), .o_src(src1), .o_busy(busy1)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc_n = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    // Model: cycles elapsed since the last grant decides the phase; 0 means idle.
    int          m_since[2] = '{0, 0};
    int          m_last[2]  = '{2, 2};
    int          m_src[2]   = '{0, 0};
    logic [15:0] m_pinc[2]  = '{16'h0, 16'h0};
    logic [15:0] m_poff[2]  = '{16'h0, 16'h0};
    int          hcy[2]     = '{4, 0};

    typedef struct {
        int          cyc;
        logic [15:0] pinc;
        logic [15:0] poff;
        int          src;
    } strobe_t;
    strobe_t sq0[$];
    strobe_t sq1[$];
    int      b2b1 = 0;
    logic    prev_cfg1 = 1'b0;

    task automatic model_step(input int u, input logic en, input logic [2:0] v,
                              input logic [47:0] pi, input logic [47:0] po,
                              input logic [2:0] rdy, input logic [15:0] opi,
                              input logic [15:0] opo, input logic cfg,
                              input logic [1:0] src, input logic busy, input logic rst_ok);
        logic exp_busy, exp_cfg;
        int   winner;
        logic [2:0] exp_rdy;
        if (!rst_ok) begin
            m_since[u] = 0; m_last[u] = 2; m_src[u] = 0; m_pinc[u] = '0; m_poff[u] = '0;
        end
        exp_busy = (m_since[u] >= 1) && (m_since[u] <= 1 + hcy[u]);
        exp_cfg  = (m_since[u] == 1);
        winner   = -1;
        if (!exp_busy && en) begin
            for (int off = 1; off <= 3; off++) begin
                int k;
                k = (m_last[u] + off) % 3;
                if (winner < 0 && v[k]) winner = k;
            end
        end
        exp_rdy = (winner >= 0) ? 3'(1 << winner) : 3'b000;
        chk($sformatf("u%0d_ready", u), rdy, exp_rdy);
        chk($sformatf("u%0d_cfg_valid", u), cfg, exp_cfg);
        chk($sformatf("u%0d_busy", u), busy, exp_busy);
        chk($sformatf("u%0d_pinc", u), opi, m_pinc[u]);
        chk($sformatf("u%0d_poff", u), opo, m_poff[u]);
        chk($sformatf("u%0d_src", u), src, m_src[u]);
        if (rst_ok) begin
            if (m_since[u] > 0) begin
                m_since[u]++;
                if (m_since[u] > 1 + hcy[u]) m_since[u] = 0;
            end
            if (winner >= 0) begin
                m_pinc[u]  = pi[winner*16 +: 16];
                m_poff[u]  = po[winner*16 +: 16];
                m_src[u]   = winner;
                m_last[u]  = winner;
                m_since[u] = 1;
            end
        end
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        model_step(0, en0, v0, pi0, po0, rdy0, opi0, opo0, cfg0, src0, busy0, rst_n);
        model_step(1, en1, v1, pi1, po1, rdy1, opi1, opo1, cfg1, src1, busy1, rst_n);
        if (rst_n && cfg0) sq0.push_back('{cyc_n, opi0, opo0, int'(src0)});
        if (rst_n && cfg1) sq1.push_back('{cyc_n, opi1, opo1, int'(src1)});
        if (rst_n && cfg1 && prev_cfg1) b2b1++;
        prev_cfg1 = cfg1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int t0;

    initial begin
        #2;
        chk("reset_pinc", opi0, 16'h0);
        chk("reset_busy", busy0, 1'b0);
        chk("reset_cfg_valid", cfg0, 1'b0);
        chk("reset_src", src0, 2'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // 1: single requester 1
        pi0 = {16'h0300, 16'h0100, 16'h0011};
        po0 = {16'h3333, 16'h0000, 16'h1111};
        sq0.delete();
        v0 = 3'b010;
        #1;
        chk("t1_ready_same_cycle", rdy0, 3'b010);
        t0 = cyc_n;
        cyc(1);
        v0 = 3'b000;
        cyc(8);
        chk("t1_strobe_count", sq0.size(), 1);
        chk("t1_strobe_cycle", sq0[0].cyc, t0 + 1);
        chk("t1_strobe_pinc", sq0[0].pinc, 16'h0100);
        chk("t1_strobe_poff", sq0[0].poff, 16'h0000);
        chk("t1_strobe_src", sq0[0].src, 1);

        // 2: three requesters held valid after a fresh reset
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        pi0 = {16'h0030, 16'h0020, 16'h0010};
        po0 = {16'h0C00, 16'h0B00, 16'h0A00};
        sq0.delete();
        v0 = 3'b111;
        cyc(19);
        v0 = 3'b000;
        cyc(8);
        chk("t2_strobe_count", sq0.size(), 4);
        chk("t2_pinc0", sq0[0].pinc, 16'h0010);
        chk("t2_pinc1", sq0[1].pinc, 16'h0020);
        chk("t2_pinc2", sq0[2].pinc, 16'h0030);
        chk("t2_pinc3", sq0[3].pinc, 16'h0010);
        for (int i = 1; i < sq0.size(); i++)
            chk("t2_spacing", sq0[i].cyc - sq0[i-1].cyc, 6);

        // 3: enable gating
        sq0.delete();
        en0 = 1'b0;
        v0  = 3'b100;
        cyc(5);
        chk("t3_no_strobe_disabled", sq0.size(), 0);
        chk("t3_no_ready_disabled", rdy0, 3'b000);
        en0 = 1'b1;
        #1;
        chk("t3_ready_on_enable", rdy0, 3'b100);
        t0 = cyc_n;
        cyc(1);
        v0 = 3'b000;
        cyc(8);
        chk("t3_strobe_count", sq0.size(), 1);
        chk("t3_strobe_cycle", sq0[0].cyc, t0 + 1);
        chk("t3_strobe_pinc", sq0[0].pinc, 16'h0030);

        // 4: asynchronous reset during hold-off
        v0 = 3'b111;
        cyc(3);
        chk("t4_busy_before_reset", busy0, 1'b1);
        #2;
        rst_n = 1'b0;
        v0    = 3'b000;
        #1;
        chk("t4_async_pinc", opi0, 16'h0);
        chk("t4_async_busy", busy0, 1'b0);
        chk("t4_async_cfg", cfg0, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        sq0.delete();
        v0 = 3'b111;
        cyc(1);
        v0 = 3'b000;
        cyc(8);
        chk("t4_first_after_reset_src", sq0[0].src, 0);
        chk("t4_first_after_reset_pinc", sq0[0].pinc, 16'h0010);

        // 5: zero hold-off, requester 0 always valid
        sq1.delete();
        pi1 = {16'h0, 16'h0, 16'h0ABC};
        po1 = {16'h0, 16'h0, 16'h0DEF};
        v1  = 3'b001;
        cyc(10);
        v1 = 3'b000;
        cyc(3);
        chk("t5_strobe_count", sq1.size(), 5);
        for (int i = 1; i < sq1.size(); i++)
            chk("t5_spacing", sq1[i].cyc - sq1[i-1].cyc, 2);
        chk("t5_no_back_to_back", b2b1, 0);
        chk("t5_pinc", sq1[0].pinc, 16'h0ABC);

        // 6: requester 1 blip during hold-off keeps its turn
        sq0.delete();
        v0 = 3'b001;
        cyc(1);
        v0 = 3'b000;
        cyc(2);
        v0 = 3'b010;
        cyc(1);
        v0 = 3'b000;
        cyc(6);
        chk("t6_single_strobe", sq0.size(), 1);
        v0 = 3'b011;
        cyc(1);
        v0 = 3'b000;
        cyc(8);
        chk("t6_strobe_count", sq0.size(), 2);
        chk("t6_first_src", sq0[0].src, 0);
        chk("t6_second_src", sq0[1].src, 1);
        chk("t6_second_pinc", sq0[1].pinc, 16'h0020);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
